// File: rtl/sstack_pkg.sv
// Shared definitions for the return-address shadow stack with memory spill/fill.
// Holds the state encoding, the parameter defaults and the spill-slot address helper.
package sstack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int          DEPTH_DEF     = 8;
    localparam int          MAX_SPILL_DEF = 256;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_F000;

    // Word address of spill slot idx; wraps modulo 2^32.
    function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/sstack_ring.sv
// On-chip return-address ring: top pointer grows on push, bottom pointer advances
// when the oldest entry has been spilled; the controller keeps push/pop/commit exclusive.
module sstack_ring #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          commit,
    input  logic [31:0]   data,
    output logic [31:0]   top_data,
    output logic [31:0]   bot_data,
    output logic [OW-1:0] occ
);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] bot;

    always_ff @(posedge clk) begin
        if (push || commit)
            mem[top] <= data;
    end

    // A commit reuses the slot just freed by the spill, so occupancy is unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top <= '0;
            bot <= '0;
            occ <= '0;
        end else if (push) begin
            top <= top + 1'b1;
            occ <= occ + 1'b1;
        end else if (commit) begin
            top <= top + 1'b1;
            bot <= bot + 1'b1;
        end else if (pop) begin
            top <= top - 1'b1;
            occ <= occ - 1'b1;
        end
    end

    assign top_data = mem[top - 1'b1];
    assign bot_data = mem[bot];

endmodule

// File: rtl/sstack_spill_ctrl.sv
// Shadow-stack controller: serves push/pop from the on-chip ring and spills the oldest
// entry to memory when full, refilling from memory when the ring runs empty.
module sstack_spill_ctrl
    import sstack_pkg::*;
#(
    parameter int          DEPTH     = DEPTH_DEF,
    parameter int          MAX_SPILL = MAX_SPILL_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic [3:0]  occ_o,
    output logic [1:0]  state_o
);

    localparam int SW = $clog2(MAX_SPILL) + 1;
    localparam int OW = $clog2(DEPTH) + 1;

    state_t        state, state_nx;
    logic [SW-1:0] spill_cnt;
    logic [31:0]   push_hold;
    logic [OW-1:0] occ;
    logic [31:0]   top_data, bot_data, r_wdata;
    logic          r_push, r_pop, r_commit;
    logic          full, empty, spill_room;
    logic          start_spill, start_fill, set_ovf, set_unf;

    assign full       = (occ == OW'(DEPTH));
    assign empty      = (occ == '0);
    assign spill_room = (spill_cnt < SW'(MAX_SPILL));

    sstack_ring #(.DEPTH(DEPTH)) u_ring (
        .clk      (clk),
        .reset    (reset),
        .push     (r_push),
        .pop      (r_pop),
        .commit   (r_commit),
        .data     (r_wdata),
        .top_data (top_data),
        .bot_data (bot_data),
        .occ      (occ)
    );

    // Pop has priority over a simultaneous push; the push is dropped.
    always_comb begin
        state_nx    = state;
        r_push      = 1'b0;
        r_pop       = 1'b0;
        r_commit    = 1'b0;
        r_wdata     = data_i;
        start_spill = 1'b0;
        start_fill  = 1'b0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop_i) begin
                    if (!empty)              r_pop = 1'b1;
                    else if (spill_cnt != 0) begin start_fill = 1'b1; state_nx = ST_FILL;  end
                    else                     begin set_unf = 1'b1;    state_nx = ST_ERROR; end
                end else if (push_i) begin
                    if (!full)               r_push = 1'b1;
                    else if (spill_room)     begin start_spill = 1'b1; state_nx = ST_SPILL; end
                    else                     begin set_ovf = 1'b1;     state_nx = ST_ERROR; end
                end
            end
            ST_SPILL: begin
                if (mem_ack_i) begin
                    r_commit = 1'b1;
                    r_wdata  = push_hold;
                    state_nx = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem_ack_i)
                    state_nx = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            spill_cnt   <= '0;
            push_hold   <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_o <= 1'b0;
            if (r_pop) begin
                data_o  <= top_data;
                valid_o <= 1'b1;
            end
            if (start_spill) begin
                push_hold   <= data_i;
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= slot_addr(BASE_ADDR, 32'(spill_cnt));
                mem_wdata_o <= bot_data;
            end
            if (start_fill) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= slot_addr(BASE_ADDR, 32'(spill_cnt - 1'b1));
            end
            if (state == ST_SPILL && mem_ack_i) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                spill_cnt <= spill_cnt + 1'b1;
            end
            if (state == ST_FILL && mem_ack_i) begin
                mem_req_o <= 1'b0;
                data_o    <= mem_rdata_i;
                valid_o   <= 1'b1;
                spill_cnt <= spill_cnt - 1'b1;
            end
            if (set_ovf) overflow_o  <= 1'b1;
            if (set_unf) underflow_o <= 1'b1;
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;
    assign occ_o   = 4'(occ);

endmodule

// File: doc/sstack_spill_ctrl.md
SSTACK_SPILL_CTRL -- requirements
Module: sstack_spill_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: on-chip return-address ring entries, a power of 2.
REQ-002 Parameter MAX_SPILL, default 256: maximum entries spilled to memory.
REQ-003 Parameter BASE_ADDR, default 32'h0000_F000: word-aligned base of the spill region.
REQ-004 The block SHALL have exactly one clock and one reset: clk is the single clock (rising edge); reset is asynchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- push_i  in  1  push request (call observed)
- pop_i  in  1  pop request (return observed)
- data_i  in  32  push data
- data_o  out  32  popped return address
- valid_o  out  1  data_o valid pulse
- busy_o  out  1  requests not accepted
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write (spill), 0 = read (fill)
- mem_addr_o  out  32  memory word address
- mem_wdata_o  out  32  spill data
- mem_rdata_i  in  32  fill data
- mem_ack_i  in  1  memory completion strobe
- overflow_o  out  1  sticky overflow
- underflow_o  out  1  sticky underflow
- occ_o  out  4  on-chip occupancy, 0..DEPTH
- state_o  out  2  FSM state

Function
REQ-006 FSM states: IDLE=0, SPILL=1, FILL=2, ERROR=3; state_o SHALL show the current state.
REQ-007 busy_o SHALL be 1 in any state other than IDLE; push_i and pop_i SHALL be ignored while busy_o=1.
REQ-008 If push_i and pop_i are both high in IDLE, the pop SHALL be served and the push dropped.
REQ-009 Push in IDLE with occ<DEPTH:
- data_i written at the top pointer
- top pointer +1 mod DEPTH, occ+1
- all three effective at the next edge
REQ-010 Push in IDLE with occ==DEPTH and spill_cnt<MAX_SPILL:
- data_i latched; go to SPILL
- mem_req_o=1, mem_we_o=1
- mem_addr_o=BASE_ADDR+4*spill_cnt
- mem_wdata_o=entry at the bottom pointer
REQ-011 In SPILL, on mem_ack_i:
- bottom pointer +1 mod DEPTH, spill_cnt+1
- latched push written at top, top pointer +1
- occ stays DEPTH; mem_req_o drops; return to IDLE
REQ-012 Push with occ==DEPTH and spill_cnt==MAX_SPILL: overflow_o=1 and go to ERROR.
REQ-013 Pop in IDLE with occ>0: top pointer -1, occ-1; data_o=popped entry with valid_o=1 exactly one cycle after pop_i.
REQ-014 Pop in IDLE with occ==0 and spill_cnt>0:
- go to FILL
- mem_req_o=1, mem_we_o=0
- mem_addr_o=BASE_ADDR+4*(spill_cnt-1)
REQ-015 In FILL, on mem_ack_i:
- data_o=mem_rdata_i and valid_o=1 on the next cycle
- spill_cnt-1; ring not written; return to IDLE
REQ-016 Pop with occ==0 and spill_cnt==0: underflow_o=1, valid_o=0, go to ERROR.
REQ-017 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL stay stable from assertion until the cycle of mem_ack_i; mem_ack_i outside SPILL/FILL SHALL be ignored.
REQ-018 ERROR SHALL be exited only by reset; overflow_o and underflow_o SHALL hold until reset.
REQ-019 valid_o SHALL be a single-cycle pulse; data_o SHALL hold its last value otherwise.
REQ-020 Address arithmetic SHALL be 32-bit unsigned; spill_cnt width SHALL be clog2(MAX_SPILL)+1.

Reset
REQ-021 On reset, all of the following SHALL take effect immediately and asynchronously:
- state=IDLE
- top/bottom pointers=0, occ=0, spill_cnt=0
- data_o=0
- valid_o, busy_o, mem_req_o, mem_we_o, overflow_o, underflow_o=0
- mem_addr_o=mem_wdata_o=0
REQ-022 Reset during SPILL/FILL SHALL abandon the transaction; a later mem_ack_i SHALL be ignored.

Structure
REQ-023 Package sstack_pkg SHALL hold the state encoding, DEPTH, MAX_SPILL and BASE_ADDR defaults.
REQ-024 The ring storage with its top/bottom pointers SHALL be a sub-module named sstack_ring; the FSM and memory handshake SHALL stay in sstack_spill_ctrl.

Verification
REQ-025 Push 0x100, 0x104, 0x108, then pop 3 times -> data_o 0x108, 0x104, 0x100; valid_o one cycle after each pop; occ_o ends 0.
REQ-026 Push 9 values 0x1..0x9 with ack latency 3 -> one write of 0x1 to 0x0000_F000; busy_o high 4 cycles; occ_o=8.
REQ-027 After REQ-026, pop 9 times -> 0x9..0x2 from the ring, then a read of 0x0000_F000 and data_o=0x1; no underflow.
REQ-028 Pop on an empty controller -> underflow_o=1, state_o=3; further push_i ignored until reset.
REQ-029 With MAX_SPILL=2, push 11 values -> overflow_o=1 on the 11th, state_o=3.
REQ-030 Assert reset mid-SPILL, then mem_ack_i -> mem_req_o=0 at once, occ_o=0, no state change on the ack.
